control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Main decoder of the single-cycle processor: maps the 4-bit instruction opcode to datapath
//  control strobes (register destination, branch, memory, ALU, write-back). Sits between
//  instruction memory and datapath muxes, register file, ALU control and data memory.
//  Outputs are registered: one clock, synchronous active-high reset.
// PARAMETERS
//  none (opcode width 4 and the opcode map are fixed)
// PORTS
//  clk       in   1  clock; all state updates on rising edge
//  rst       in   1  synchronous active-high reset
//  opcode    in   4  instruction opcode field
//  RegDst    out  1  1: write rd (R-type); 0: write rt
//  Branch    out  1  conditional branch instruction
//  Bneq      out  1  with Branch: take branch on not-equal (bne); 0: on equal (beq)
//  MemRead   out  1  data memory read enable
//  MemtoReg  out  1  1: write-back data from memory; 0: from ALU
//  AluOp2    out  1  ALU op code bit 2 (MSB)
//  AluOp1    out  1  ALU op code bit 1
//  AluOp0    out  1  ALU op code bit 0 (LSB)
//  MemWrite  out  1  data memory write enable
//  AluSrc    out  1  1: ALU B operand = sign/zero-extended immediate; 0: register rt
//  RegWrite  out  1  register file write enable
//  Slti      out  1  set-less-than-immediate: write-back = ALU sign/less-than result
//  illegal   out  1  opcode not in map (1010..1111)
// BEHAVIOUR
//  - Reset: on rising clk with rst=1 all outputs, incl. illegal, become 0; rst overrides opcode.
//  - Otherwise every rising edge registers decode(opcode); latency exactly 1 cycle, no handshake.
//  - AluOp[2:0] = {AluOp2,AluOp1,AluOp0}: 000 add, 001 sub, 010 and, 011 or, 100 nor, 111 R-type (ALU control uses funct).
//  - Decode table (signals not listed are 0):
//    0000 R-type: RegDst, RegWrite, AluOp=111
//    0001 addi : AluSrc, RegWrite, AluOp=000
//    0010 andi : AluSrc, RegWrite, AluOp=010
//    0011 ori  : AluSrc, RegWrite, AluOp=011
//    0100 nori : AluSrc, RegWrite, AluOp=100
//    0101 beq  : Branch, AluOp=001
//    0110 bne  : Branch, Bneq, AluOp=001
//    0111 slti : AluSrc, RegWrite, Slti, AluOp=001
//    1000 lw   : MemRead, MemtoReg, AluSrc, RegWrite, AluOp=000
//    1001 sw   : MemWrite, AluSrc, AluOp=000
//    1010..1111: all strobes 0 (NOP, no state change), illegal=1
//  - Invariants every cycle: MemRead & MemWrite never both 1; Bneq=1 only with Branch=1;
//    RegWrite=0 whenever Branch or MemWrite=1; Slti=1 only with RegWrite=1.
//  - X/Z on opcode treated as illegal (decode to NOP, illegal=1); no latch inference.
//  - Reset asserted mid-stream clears outputs on that edge; first opcode after deassert decoded next edge.
// TESTING
//  - Reset: rst=1 with opcode=0000 for 2 cycles -> all outputs 0 incl. RegDst/RegWrite/illegal.
//  - Sweep 0000..1001 one per cycle -> one edge later outputs match table row exactly
//    (e.g. 1000 -> MemRead=MemtoReg=AluSrc=RegWrite=1, AluOp=000, rest 0).
//  - Branches: 0101 -> Branch=1,Bneq=0,AluOp=001; 0110 -> Branch=1,Bneq=1,AluOp=001, RegWrite=0.
//  - Illegal: 1010..1111 -> all strobes 0, illegal=1; then 0001 -> illegal=0, AluSrc=RegWrite=1.
//  - Latency: change opcode 0000->1001 mid-cycle -> outputs hold R-type until next rising edge.
//  - Reset mid-operation: opcode=1000 decoded, assert rst one cycle -> outputs 0, resume next edge after release.

Source files
------------

// File: rtl/control_unit_if.sv
// Opcode in, registered decode strobes out; the names match the datapath's control pins.
interface control_unit_if;
  logic [3:0] opcode;
  logic       RegDst, Branch, Bneq, MemRead, MemtoReg;
  logic       AluOp2, AluOp1, AluOp0;
  logic       MemWrite, AluSrc, RegWrite, Slti, illegal;

  modport master (
    output opcode,
    input  RegDst, Branch, Bneq, MemRead, MemtoReg, AluOp2, AluOp1, AluOp0,
           MemWrite, AluSrc, RegWrite, Slti, illegal
  );
  modport slave (
    input  opcode,
    output RegDst, Branch, Bneq, MemRead, MemtoReg, AluOp2, AluOp1, AluOp0,
           MemWrite, AluSrc, RegWrite, Slti, illegal
  );
endinterface

// File: rtl/control_unit.sv
// Main decoder: 4-bit opcode -> datapath control strobes, registered with one cycle latency.
module control_unit (
  input  logic           clk,
  input  logic           rst,
  control_unit_if.slave  bus
);
  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       bneq;
    logic       mem_read;
    logic       mem_to_reg;
    logic [2:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       slti;
    logic       illegal;
  } ctrl_t;

  ctrl_t dec, q;

  // Unmatched opcodes (including X/Z) fall to default and decode as an illegal NOP.
  always_comb begin
    dec = '0;
    case (bus.opcode)
      4'b0000: begin dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 3'b111; end
      4'b0001: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 3'b000; end
      4'b0010: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 3'b010; end
      4'b0011: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 3'b011; end
      4'b0100: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 3'b100; end
      4'b0101: begin dec.branch  = 1'b1; dec.alu_op = 3'b001; end
      4'b0110: begin dec.branch  = 1'b1; dec.bneq = 1'b1; dec.alu_op = 3'b001; end
      4'b0111: begin
        dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.slti = 1'b1; dec.alu_op = 3'b001;
      end
      4'b1000: begin
        dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
      end
      4'b1001: begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; end
      default: dec.illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= dec;
  end

  assign bus.RegDst   = q.reg_dst;
  assign bus.Branch   = q.branch;
  assign bus.Bneq     = q.bneq;
  assign bus.MemRead  = q.mem_read;
  assign bus.MemtoReg = q.mem_to_reg;
  assign bus.AluOp2   = q.alu_op[2];
  assign bus.AluOp1   = q.alu_op[1];
  assign bus.AluOp0   = q.alu_op[0];
  assign bus.MemWrite = q.mem_write;
  assign bus.AluSrc   = q.alu_src;
  assign bus.RegWrite = q.reg_write;
  assign bus.Slti     = q.slti;
  assign bus.illegal  = q.illegal;
endmodule

// File: tb/tb_control_unit.sv
// Directed vectors for control_unit; outputs packed as
// {RegDst,Branch,Bneq,MemRead,MemtoReg,AluOp[2:0],MemWrite,AluSrc,RegWrite,Slti,illegal}.
module tb_control_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  control_unit_if bus ();
  control_unit dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  localparam logic [12:0] EXP_ZERO = 13'b00000_000_00000;
  localparam logic [12:0] EXP_ILL  = 13'b00000_000_00001;
  logic [12:0] exp_tab [10];

  initial begin
    exp_tab[0] = 13'b10000_111_00100; // R-type
    exp_tab[1] = 13'b00000_000_01100; // addi
    exp_tab[2] = 13'b00000_010_01100; // andi
    exp_tab[3] = 13'b00000_011_01100; // ori
    exp_tab[4] = 13'b00000_100_01100; // nori
    exp_tab[5] = 13'b01000_001_00000; // beq
    exp_tab[6] = 13'b01100_001_00000; // bne
    exp_tab[7] = 13'b00000_001_01110; // slti
    exp_tab[8] = 13'b00011_000_01100; // lw
    exp_tab[9] = 13'b00000_000_11000; // sw
  end

  function automatic logic [12:0] outs();
    return {bus.RegDst, bus.Branch, bus.Bneq, bus.MemRead, bus.MemtoReg,
            bus.AluOp2, bus.AluOp1, bus.AluOp0,
            bus.MemWrite, bus.AluSrc, bus.RegWrite, bus.Slti, bus.illegal};
  endfunction

  task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic invariants(input string tag);
    chk({tag, "_inv_mrw"}, 13'(bus.MemRead & bus.MemWrite), 13'd0);
    chk({tag, "_inv_bneq"}, 13'(bus.Bneq & ~bus.Branch), 13'd0);
    chk({tag, "_inv_rw"}, 13'(bus.RegWrite & (bus.Branch | bus.MemWrite)), 13'd0);
    chk({tag, "_inv_slti"}, 13'(bus.Slti & ~bus.RegWrite), 13'd0);
  endtask

  // Drive on the falling edge, sample just after the next rising edge.
  task automatic step(input logic [3:0] op, input logic [12:0] exp, input string tag);
    @(negedge clk) bus.opcode = op;
    @(posedge clk) #1;
    chk(tag, outs(), exp);
    invariants(tag);
  endtask

  initial begin
    rst = 1'b1;
    bus.opcode = 4'b0000;
    repeat (2) begin
      @(posedge clk) #1;
      chk("reset", outs(), EXP_ZERO);
    end
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 10; i++)
      step(4'(i), exp_tab[i], $sformatf("op%0d", i));

    for (int i = 10; i < 16; i++)
      step(4'(i), EXP_ILL, $sformatf("illegal%0d", i));
    step(4'b0001, exp_tab[1], "addi_after_illegal");

    // Opcode change mid-cycle must not reach the outputs before the edge.
    step(4'b0000, exp_tab[0], "lat_rtype");
    #2 bus.opcode = 4'b1001;
    #1 chk("lat_hold", outs(), exp_tab[0]);
    @(posedge clk) #1;
    chk("lat_sw", outs(), exp_tab[9]);

    // Reset in the middle of a stream.
    step(4'b1000, exp_tab[8], "pre_rst_lw");
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    chk("mid_rst", outs(), EXP_ZERO);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    chk("post_rst_lw", outs(), exp_tab[8]);
    step(4'b0110, exp_tab[6], "post_rst_bne");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
